// File: rtl/rv32_multicycle_control_pkg.sv
// Shared encodings for the RV32 multicycle controller: FSM states, opcodes,
// datapath select codes and the packed control word driven each cycle.
package rv32_multicycle_control_pkg;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXEC_R    = 4'd2;
    localparam logic [3:0] S_EXEC_I    = 4'd3;
    localparam logic [3:0] S_ALU_WB    = 4'd4;
    localparam logic [3:0] S_MEM_ADDR  = 4'd5;
    localparam logic [3:0] S_MEM_RD    = 4'd6;
    localparam logic [3:0] S_MEM_WR    = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JAL_LINK  = 4'd9;
    localparam logic [3:0] S_JALR_CALC = 4'd10;
    localparam logic [3:0] S_JUMP      = 4'd11;
    localparam logic [3:0] S_LUI       = 4'd12;
    localparam logic [3:0] S_AUIPC     = 4'd13;
    localparam logic [3:0] S_TRAP      = 4'd14;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] OP1_RS1    = 2'b00;
    localparam logic [1:0] OP1_PC     = 2'b01;
    localparam logic [1:0] OP1_OLD_PC = 2'b10;
    localparam logic [1:0] OP1_ZERO   = 2'b11;
    localparam logic [1:0] OP2_IMM    = 2'b00;
    localparam logic [1:0] OP2_FOUR   = 2'b01;
    localparam logic [1:0] OP2_RS2    = 2'b10;
    localparam logic [1:0] OP2_ZERO   = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef struct packed {
        logic       pc_enable;
        logic       old_pc_enable;
        logic       ir_reg_enable;
        logic       alu_reg_enable;
        logic       rf_we;
        logic       mem_enable;
        logic       mem_write_enable;
        logic       memsel_mux_select;
        logic       regfile_mux_select;
        logic       alu_reg_mux_select;
        logic [1:0] opsel1_select;
        logic [1:0] opsel2_select;
        logic [2:0] imm_src;
        logic [2:0] alu_sel;
        logic       instr_retired;
        logic       trap;
        logic [1:0] trap_cause;
    } ctrl_t;

endpackage

// File: rtl/rv32_multicycle_control_if.sv
// Controller <-> datapath bundle: status from the datapath, enables/selects back to it.
interface rv32_multicycle_control_if;
    logic [31:0] ir;
    logic        zero;
    logic        mem_op_r;
    logic        pc_enable;
    logic        old_pc_enable;
    logic        ir_reg_enable;
    logic        alu_reg_enable;
    logic        rf_we;
    logic        mem_enable;
    logic        mem_write_enable;
    logic        memsel_mux_select;
    logic        regfile_mux_select;
    logic        alu_reg_mux_select;
    logic [1:0]  opsel1_select;
    logic [1:0]  opsel2_select;
    logic [2:0]  imm_src;
    logic [2:0]  alu_sel;
    logic        instr_retired;
    logic        trap;
    logic [1:0]  trap_cause;

    modport master (
        input  ir, zero, mem_op_r,
        output pc_enable, old_pc_enable, ir_reg_enable, alu_reg_enable, rf_we,
               mem_enable, mem_write_enable, memsel_mux_select, regfile_mux_select,
               alu_reg_mux_select, opsel1_select, opsel2_select, imm_src, alu_sel,
               instr_retired, trap, trap_cause
    );

    modport slave (
        output ir, zero, mem_op_r,
        input  pc_enable, old_pc_enable, ir_reg_enable, alu_reg_enable, rf_we,
               mem_enable, mem_write_enable, memsel_mux_select, regfile_mux_select,
               alu_reg_mux_select, opsel1_select, opsel2_select, imm_src, alu_sel,
               instr_retired, trap, trap_cause
    );
endinterface

// File: rtl/rv32_multicycle_control_alu_decoder.sv
// Maps funct3/funct7[5] to an ALU operation and flags encodings outside the subset.
module rv32_multicycle_control_alu_decoder
    import rv32_multicycle_control_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       is_rtype,
    output logic [2:0] alu_sel,
    output logic       legal
);

    always_comb begin
        alu_sel = ALU_ADD;
        legal   = 1'b1;
        case (funct3)
            3'b000: alu_sel = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b111: alu_sel = ALU_AND;
            3'b110: alu_sel = ALU_OR;
            3'b100: alu_sel = ALU_XOR;
            3'b010: alu_sel = ALU_SLT;
            3'b001: alu_sel = ALU_SLL;
            // Logical right shift only; funct7[5] set (SRA/SRAI) is outside the subset
            3'b101: begin
                alu_sel = ALU_SRL;
                legal   = ~funct7_b5;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32_multicycle_control.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/mem/writeback and
// traps (sticky until reset) on unsupported encodings or memory timeouts.
module rv32_multicycle_control
    import rv32_multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    rv32_multicycle_control_if.master   bus
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0]       cause_reg, cause_next;
    ctrl_t            ctrl, ctrl_out;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_rtype, is_shift, dec_f7b5, alu_legal, wait_limit, waiting;
    logic [2:0] dec_alu_sel;
    logic       unused_ir;

    assign opcode    = bus.ir[6:0];
    assign funct3    = bus.ir[14:12];
    assign is_rtype  = (opcode == OPC_R);
    assign is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign dec_f7b5  = (is_rtype || is_shift) ? bus.ir[30] : 1'b0;
    assign unused_ir = ^{bus.ir[31], bus.ir[29:15], bus.ir[11:7]};

    rv32_multicycle_control_alu_decoder u_alu_dec (
        .funct3    (funct3),
        .funct7_b5 (dec_f7b5),
        .is_rtype  (is_rtype),
        .alu_sel   (dec_alu_sel),
        .legal     (alu_legal)
    );

    // The limit cycle is the MEM_TIMEOUT-th wait cycle; mem_op_r there still completes
    assign wait_limit = (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1));
    assign waiting    = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) || (state_reg == S_MEM_WR);

    always_comb begin
        ctrl       = '0;
        state_next = state_reg;
        cause_next = cause_reg;
        case (state_reg)
            S_FETCH: begin
                ctrl.mem_enable = 1'b1;
                if (bus.mem_op_r) begin
                    ctrl.ir_reg_enable      = 1'b1;
                    ctrl.old_pc_enable      = 1'b1;
                    ctrl.pc_enable          = 1'b1;
                    ctrl.opsel1_select      = OP1_PC;
                    ctrl.opsel2_select      = OP2_FOUR;
                    ctrl.alu_reg_mux_select = 1'b1;
                    state_next              = S_DECODE;
                end else if (wait_limit) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                // Branch/jump target precomputed from old_pc while the opcode is decoded
                ctrl.opsel1_select  = OP1_OLD_PC;
                ctrl.opsel2_select  = OP2_IMM;
                ctrl.alu_reg_enable = 1'b1;
                ctrl.imm_src        = (opcode == OPC_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OPC_R:                 state_next = S_EXEC_R;
                    OPC_I:                 state_next = S_EXEC_I;
                    OPC_LOAD, OPC_STORE:   state_next = S_MEM_ADDR;
                    OPC_BRANCH:            state_next = S_BRANCH;
                    OPC_JAL:               state_next = S_JAL_LINK;
                    OPC_JALR:              state_next = S_JALR_CALC;
                    OPC_LUI:               state_next = S_LUI;
                    OPC_AUIPC:             state_next = S_AUIPC;
                    default: begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: begin
                if (alu_legal) begin
                    ctrl.opsel1_select  = OP1_RS1;
                    ctrl.opsel2_select  = (state_reg == S_EXEC_R) ? OP2_RS2 : OP2_IMM;
                    ctrl.imm_src        = IMM_I;
                    ctrl.alu_sel        = dec_alu_sel;
                    ctrl.alu_reg_enable = 1'b1;
                    state_next          = S_ALU_WB;
                end else begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            S_ALU_WB: begin
                ctrl.rf_we              = 1'b1;
                ctrl.regfile_mux_select = 1'b1;
                ctrl.instr_retired      = 1'b1;
                state_next              = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.opsel1_select = OP1_RS1;
                ctrl.opsel2_select = OP2_IMM;
                ctrl.imm_src       = (opcode == OPC_STORE) ? IMM_S : IMM_I;
                if (funct3 != 3'b010) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end else begin
                    ctrl.alu_reg_enable = 1'b1;
                    state_next = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
                end
            end
            S_MEM_RD, S_MEM_WR: begin
                ctrl.mem_enable        = 1'b1;
                ctrl.memsel_mux_select = 1'b1;
                ctrl.mem_write_enable  = (state_reg == S_MEM_WR);
                if (bus.mem_op_r) begin
                    ctrl.rf_we         = (state_reg == S_MEM_RD);
                    ctrl.instr_retired = 1'b1;
                    state_next         = S_FETCH;
                end else if (wait_limit) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_BRANCH: begin
                ctrl.opsel1_select = OP1_RS1;
                ctrl.opsel2_select = OP2_RS2;
                ctrl.alu_sel       = ALU_SUB;
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    // alu_reg still holds the target from DECODE
                    ctrl.pc_enable     = (funct3 == 3'b000) ? bus.zero : ~bus.zero;
                    ctrl.instr_retired = 1'b1;
                    state_next         = S_FETCH;
                end else begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end
            end
            S_JAL_LINK: begin
                ctrl.opsel1_select      = OP1_OLD_PC;
                ctrl.opsel2_select      = OP2_FOUR;
                ctrl.alu_reg_mux_select = 1'b1;
                ctrl.regfile_mux_select = 1'b1;
                ctrl.rf_we              = 1'b1;
                state_next              = S_JUMP;
            end
            S_JALR_CALC: begin
                // Target LSB is deliberately left as computed
                ctrl.opsel1_select  = OP1_RS1;
                ctrl.opsel2_select  = OP2_IMM;
                ctrl.imm_src        = IMM_I;
                ctrl.alu_reg_enable = 1'b1;
                state_next          = S_JAL_LINK;
            end
            S_JUMP: begin
                ctrl.pc_enable     = 1'b1;
                ctrl.instr_retired = 1'b1;
                state_next         = S_FETCH;
            end
            S_LUI, S_AUIPC: begin
                ctrl.opsel1_select      = (state_reg == S_LUI) ? OP1_ZERO : OP1_OLD_PC;
                ctrl.opsel2_select      = OP2_IMM;
                ctrl.imm_src            = IMM_U;
                ctrl.alu_reg_mux_select = 1'b1;
                ctrl.regfile_mux_select = 1'b1;
                ctrl.rf_we              = 1'b1;
                ctrl.instr_retired      = 1'b1;
                state_next              = S_FETCH;
            end
            S_TRAP: ctrl.trap = 1'b1;
            default: begin
                state_next = S_TRAP;
                cause_next = CAUSE_ILLEGAL;
            end
        endcase
        ctrl.trap_cause = cause_reg;
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg)
            wait_cnt_next = '0;
        else if (waiting && !bus.mem_op_r)
            wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            cause_reg    <= CAUSE_NONE;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            cause_reg    <= cause_next;
        end
    end

    assign ctrl_out = reset ? '0 : ctrl;

    assign bus.pc_enable          = ctrl_out.pc_enable;
    assign bus.old_pc_enable      = ctrl_out.old_pc_enable;
    assign bus.ir_reg_enable      = ctrl_out.ir_reg_enable;
    assign bus.alu_reg_enable     = ctrl_out.alu_reg_enable;
    assign bus.rf_we              = ctrl_out.rf_we;
    assign bus.mem_enable         = ctrl_out.mem_enable;
    assign bus.mem_write_enable   = ctrl_out.mem_write_enable;
    assign bus.memsel_mux_select  = ctrl_out.memsel_mux_select;
    assign bus.regfile_mux_select = ctrl_out.regfile_mux_select;
    assign bus.alu_reg_mux_select = ctrl_out.alu_reg_mux_select;
    assign bus.opsel1_select      = ctrl_out.opsel1_select;
    assign bus.opsel2_select      = ctrl_out.opsel2_select;
    assign bus.imm_src            = ctrl_out.imm_src;
    assign bus.alu_sel            = ctrl_out.alu_sel;
    assign bus.instr_retired      = ctrl_out.instr_retired;
    assign bus.trap               = ctrl_out.trap;
    assign bus.trap_cause         = ctrl_out.trap_cause;

endmodule
